// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: sequences exec-stage UART write/read requests onto a byte-wide PHY, with an RX FIFO.
// Optional macro UART_WORD_EN: each request moves 4 little-endian bytes instead of 1.
module uart_io_ctrl #(
    parameter int RX_AW = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_req,
    input  logic [31:0]      wr_data,
    output logic             wr_done,
    input  logic             rd_req,
    output logic             rd_done,
    output logic [31:0]      rd_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [RX_AW:0]   rx_count,
    output logic             rx_overrun
);
    localparam int DEPTH = 2 ** RX_AW;
    localparam logic [RX_AW:0]   FULL_COUNT = (RX_AW + 1)'(DEPTH);
    localparam logic [RX_AW:0]   CNT_ONE    = (RX_AW + 1)'(1);
    localparam logic [RX_AW-1:0] PTR_ONE    = RX_AW'(1);
`ifdef UART_WORD_EN
    localparam int TX_W = 32;
`else
    localparam int TX_W = 8;
`endif

    typedef enum logic {T_IDLE = 1'b0, T_SEND = 1'b1} tx_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_COLLECT = 1'b1} rx_state_t;

    tx_state_t         tx_state_r, tx_state_s;
    rx_state_t         rx_state_r, rx_state_s;
    logic [TX_W-1:0]   tx_buf_r;
    logic              tx_valid_r, wr_done_r;
    logic              tx_hs_s, tx_last_s;
    logic              rd_done_r, rx_overrun_r, rx_last_s;
    logic [31:0]       rd_data_r;
    logic [7:0]        mem_r [DEPTH];
    logic [RX_AW-1:0]  wptr_r, rptr_r;
    logic [RX_AW:0]    count_r;
    logic              full_s, pop_s, push_s;
    logic [7:0]        pop_byte_s;

`ifdef UART_WORD_EN
    logic [1:0]        tx_idx_r, rx_idx_r;
    logic [23:0]       asm_r;
    assign tx_last_s = (tx_idx_r == 2'd3);
    assign rx_last_s = (rx_idx_r == 2'd3);
`else
    logic              wr_data_unused_s;
    assign wr_data_unused_s = ^wr_data[31:8];
    assign tx_last_s = 1'b1;
    assign rx_last_s = 1'b1;
`endif

    assign full_s     = (count_r == FULL_COUNT);
    assign pop_s      = (rx_state_r == R_COLLECT) && (count_r != '0);
    assign push_s     = rx_valid && (!full_s || pop_s);
    assign pop_byte_s = mem_r[rptr_r];

    // TX next-state and handshake decode
    always_comb begin
        tx_state_s = tx_state_r;
        tx_hs_s    = 1'b0;
        case (tx_state_r)
            T_IDLE: begin
                if (wr_req) tx_state_s = T_SEND;
                else        tx_state_s = T_IDLE;
            end
            T_SEND: begin
                // tx_valid_r is high for the whole of T_SEND
                tx_hs_s = tx_ready;
                if (tx_ready && tx_last_s) tx_state_s = T_IDLE;
                else                       tx_state_s = T_SEND;
            end
            default: tx_state_s = T_IDLE;
        endcase
    end

    // TX state, byte buffer and registered TX outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_r <= T_IDLE;
            tx_valid_r <= 1'b0;
            wr_done_r  <= 1'b0;
            tx_buf_r   <= '0;
`ifdef UART_WORD_EN
            tx_idx_r   <= 2'd0;
`endif
        end else begin
            tx_state_r <= tx_state_s;
            tx_valid_r <= (tx_state_s == T_SEND);
            wr_done_r  <= tx_hs_s && tx_last_s;
            if ((tx_state_r == T_IDLE) && wr_req) begin
                tx_buf_r <= wr_data[TX_W-1:0];
`ifdef UART_WORD_EN
                tx_idx_r <= 2'd0;
`endif
            end else if (tx_hs_s) begin
`ifdef UART_WORD_EN
                tx_buf_r <= {8'h00, tx_buf_r[31:8]};
                tx_idx_r <= tx_idx_r + 2'd1;
`else
                tx_buf_r <= tx_buf_r;
`endif
            end else begin
                tx_buf_r <= tx_buf_r;
            end
        end
    end

    // RX FIFO storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= rx_data;
        end
    end

    // RX FIFO pointers, occupancy and sticky overrun
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r       <= '0;
            rptr_r       <= '0;
            count_r      <= '0;
            rx_overrun_r <= 1'b0;
        end else begin
            if (push_s) wptr_r <= wptr_r + PTR_ONE;
            if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (rx_valid && !push_s) rx_overrun_r <= 1'b1;
        end
    end

    // RX next-state decode
    always_comb begin
        rx_state_s = rx_state_r;
        case (rx_state_r)
            R_IDLE: begin
                if (rd_req) rx_state_s = R_COLLECT;
                else        rx_state_s = R_IDLE;
            end
            R_COLLECT: begin
                if (pop_s && rx_last_s) rx_state_s = R_IDLE;
                else                    rx_state_s = R_COLLECT;
            end
            default: rx_state_s = R_IDLE;
        endcase
    end

    // RX state, word assembly and registered read result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_r <= R_IDLE;
            rd_done_r  <= 1'b0;
            rd_data_r  <= 32'h0000_0000;
`ifdef UART_WORD_EN
            rx_idx_r   <= 2'd0;
            asm_r      <= 24'h00_0000;
`endif
        end else begin
            rx_state_r <= rx_state_s;
            rd_done_r  <= pop_s && rx_last_s;
            if (pop_s) begin
`ifdef UART_WORD_EN
                // first popped byte ends up in rd_data[7:0]
                asm_r    <= {pop_byte_s, asm_r[23:8]};
                rx_idx_r <= rx_idx_r + 2'd1;
                if (rx_last_s) rd_data_r <= {pop_byte_s, asm_r};
`else
                rd_data_r <= {24'h00_0000, pop_byte_s};
`endif
            end
        end
    end

    assign wr_done    = wr_done_r;
    assign tx_valid   = tx_valid_r;
    assign tx_data    = tx_buf_r[7:0];
    assign rd_done    = rd_done_r;
    assign rd_data    = rd_data_r;
    assign rx_count   = count_r;
    assign rx_overrun = rx_overrun_r;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl; a queue model of the RX FIFO and byte-order rules
// supplies every expected value. Works for both the byte build and UART_WORD_EN.
module tb_uart_io_ctrl;
    localparam int RX_AW = 4;
    localparam int DEPTH = 16;
`ifdef UART_WORD_EN
    localparam int NB = 4;
`else
    localparam int NB = 1;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             wr_req = 1'b0, rd_req = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
    logic [31:0]      wr_data = 32'h0;
    logic [7:0]       rx_data = 8'h0;
    logic             wr_done, rd_done, tx_valid, rx_overrun;
    logic [31:0]      rd_data;
    logic [7:0]       tx_data;
    logic [RX_AW:0]   rx_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];
    logic       ovr_m = 1'b0;

    uart_io_ctrl #(.RX_AW(RX_AW)) dut (
        .clk(clk), .rstn(rstn),
        .wr_req(wr_req), .wr_data(wr_data), .wr_done(wr_done),
        .rd_req(rd_req), .rd_done(rd_done), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_count(rx_count), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        if (q.size() < DEPTH) q.push_back(b);
        else                  ovr_m = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic check_fifo(input string name);
        logic [RX_AW:0] e;
        @(negedge clk);
        e = (RX_AW + 1)'(q.size());
        tests++;
        if (rx_count !== e || rx_overrun !== ovr_m) begin
            fails++;
            $display("FAIL %s: count=%0d overrun=%b expected count=%0d overrun=%b",
                     name, rx_count, rx_overrun, e, ovr_m);
        end
    endtask

    // one read request; optionally pushes inj in the cycle of the first pop
    task automatic rd_txn(input bit inject, input logic [7:0] inj);
        logic [31:0] exp;
        exp = 32'h0;
        for (int i = 0; i < NB; i++) exp[8*i +: 8] = q.pop_front();
        if (inject) q.push_back(inj);
        @(negedge clk);
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        for (int c = 0; c < NB; c++) begin
            @(negedge clk);
            tests++;
            if (rd_done !== 1'b0) begin
                fails++;
                $display("FAIL rd_early: rd_done=%b expected 0 at cycle %0d", rd_done, c);
            end
            if (c == 0 && inject) begin
                rx_valid = 1'b1;
                rx_data  = inj;
                @(posedge clk);
                #1 rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (rd_done !== 1'b1 || rd_data !== exp) begin
            fails++;
            $display("FAIL rd_done: rd_done=%b rd_data=%h expected 1 %h", rd_done, rd_data, exp);
        end
        @(negedge clk);
        tests++;
        if (rd_done !== 1'b0 || rd_data !== exp) begin
            fails++;
            $display("FAIL rd_hold: rd_done=%b rd_data=%h expected 0 %h", rd_done, rd_data, exp);
        end
    endtask

    task automatic tx_txn(input logic [31:0] d, input int stall_pct, input int forced_stall);
        int b, n;
        b = 0;
        n = 0;
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1 wr_req = 1'b0;
        wr_data = $urandom;
        while (b < NB && n < 300) begin
            @(negedge clk);
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== d[8*b +: 8] || wr_done !== 1'b0) begin
                fails++;
                $display("FAIL tx_byte: valid=%b data=%h done=%b expected 1 %h 0",
                         tx_valid, tx_data, wr_done, d[8*b +: 8]);
            end
            tx_ready = (n >= forced_stall) && ($urandom_range(99) >= stall_pct);
            if (tx_ready) b++;
            n++;
        end
        tests++;
        if (b < NB) begin
            fails++;
            $display("FAIL tx_timeout: sent %0d bytes expected %0d", b, NB);
        end
        @(negedge clk);
        tests++;
        if (wr_done !== 1'b1 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL wr_done: done=%b valid=%b expected 1 0", wr_done, tx_valid);
        end
        tx_ready = 1'($urandom_range(1));
        @(negedge clk);
        tests++;
        if (wr_done !== 1'b0) begin
            fails++;
            $display("FAIL wr_done_pulse: done=%b expected 0", wr_done);
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #3;
        tests++;
        if (wr_done !== 1'b0 || rd_done !== 1'b0 || rd_data !== 32'h0 || tx_data !== 8'h0 ||
            tx_valid !== 1'b0 || rx_count !== '0 || rx_overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset: wd=%b rd=%b rdata=%h txd=%h txv=%b cnt=%0d ovr=%b expected all 0",
                     wr_done, rd_done, rd_data, tx_data, tx_valid, rx_count, rx_overrun);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_tx_basic();
        tx_txn(32'h0000_0041, 0, 0);
        tx_txn(32'h1122_3344, 0, 0);
        for (int i = 0; i < 4; i++) tx_txn($urandom, 0, 0);
    endtask

    task automatic test_tx_stall();
        tx_txn(32'h0000_0041, 0, 5);
        for (int i = 0; i < 4; i++) tx_txn($urandom, 50, $urandom_range(3));
    endtask

    task automatic test_rd_empty();
        logic [31:0] exp;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (rd_done !== 1'b0) begin
                fails++;
                $display("FAIL rd_empty_wait: rd_done=%b expected 0", rd_done);
            end
        end
        for (int i = 0; i < NB; i++) push_byte(8'h5A + 8'(i));
        exp = 32'h0;
        for (int i = 0; i < NB; i++) exp[8*i +: 8] = q.pop_front();
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (rd_done === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || rd_data !== exp || rx_count !== '0) begin
            fails++;
            $display("FAIL rd_empty: seen=%b rd_data=%h count=%0d expected 1 %h 0",
                     seen, rd_data, rx_count, exp);
        end
    endtask

    task automatic test_rd_basic();
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        push_byte(8'hDD);
        check_fifo("rd_basic_fill");
        while (q.size() >= NB) rd_txn(1'b0, 8'h00);
        check_fifo("rd_basic_drain");
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i <= DEPTH; i++) push_byte(8'(i));
        check_fifo("fill_overrun");
        rd_txn(1'b1, 8'hE0);
        check_fifo("full_push_pop");
        while (q.size() >= NB) rd_txn(1'b0, 8'h00);
        check_fifo("fill_drain");
    endtask

    task automatic test_mid_reset();
        repeat (3) push_byte(8'($urandom));
        tx_ready = 1'b0;
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = $urandom;
        @(posedge clk);
        #1 wr_req = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        q.delete();
        ovr_m = 1'b0;
        tests++;
        if (tx_valid !== 1'b0 || rx_count !== '0 || rx_overrun !== 1'b0 || wr_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: txv=%b cnt=%0d ovr=%b wd=%b expected 0 0 0 0",
                     tx_valid, rx_count, rx_overrun, wr_done);
        end
        @(negedge clk);
        rstn     = 1'b1;
        tx_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (wr_done !== 1'b0 || tx_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_after: wd=%b txv=%b expected 0 0", wr_done, tx_valid);
            end
        end
        check_fifo("mid_reset_fifo");
    endtask

    task automatic test_concurrent();
        logic [31:0] d, exp;
        for (int i = 0; i < NB; i++) push_byte(8'($urandom));
        d   = $urandom;
        exp = 32'h0;
        for (int i = 0; i < NB; i++) exp[8*i +: 8] = q.pop_front();
        @(negedge clk);
        tx_ready = 1'b1;
        wr_req   = 1'b1;
        wr_data  = d;
        rd_req   = 1'b1;
        @(posedge clk);
        #1 wr_req = 1'b0;
        rd_req = 1'b0;
        for (int c = 0; c < NB; c++) begin
            @(negedge clk);
            tests++;
            if (wr_done !== 1'b0 || rd_done !== 1'b0 || tx_data !== d[8*c +: 8]) begin
                fails++;
                $display("FAIL concurrent_busy: wd=%b rd=%b txd=%h expected 0 0 %h",
                         wr_done, rd_done, tx_data, d[8*c +: 8]);
            end
        end
        @(negedge clk);
        tests++;
        if (wr_done !== 1'b1 || rd_done !== 1'b1 || rd_data !== exp) begin
            fails++;
            $display("FAIL concurrent_done: wd=%b rd=%b rdata=%h expected 1 1 %h",
                     wr_done, rd_done, rd_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        d1 = $urandom;
        d2 = $urandom;
        tx_ready = 1'b1;
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = d1;
        @(posedge clk);
        #1 wr_req = 1'b0;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== d1[8*b +: 8]) begin
                fails++;
                $display("FAIL b2b_first: txv=%b txd=%h expected 1 %h", tx_valid, tx_data, d1[8*b +: 8]);
            end
        end
        @(negedge clk);
        tests++;
        if (wr_done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done1: wd=%b expected 1", wr_done);
        end
        wr_req  = 1'b1;
        wr_data = d2;
        @(posedge clk);
        #1 wr_req = 1'b0;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== d2[8*b +: 8] || wr_done !== 1'b0) begin
                fails++;
                $display("FAIL b2b_second: txv=%b txd=%h wd=%b expected 1 %h 0",
                         tx_valid, tx_data, wr_done, d2[8*b +: 8]);
            end
        end
        @(negedge clk);
        tests++;
        if (wr_done !== 1'b1 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done2: wd=%b txv=%b expected 1 0", wr_done, tx_valid);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(4);
            for (int i = 0; i < k; i++) push_byte(8'($urandom));
            if (q.size() >= NB && $urandom_range(1) == 1) rd_txn(1'b0, 8'h00);
            if ($urandom_range(2) == 0) tx_txn($urandom, 40, 0);
            check_fifo("random_fifo");
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_stall();
        test_rd_empty();
        test_rd_basic();
        test_fill_overrun();
        test_mid_reset();
        test_concurrent();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
